// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern detector: captures a pattern over a valid/ready
// handshake, then runs detection on a bit stream until a target count or abort.
module seq_det_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               abort,
    input  logic               bit_valid,
    input  logic               bit_in,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               done,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_RUN     = 2'b01,
        S_DONE    = 2'b10,
        S_ILLEGAL = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic               cfg_loaded_q, cfg_loaded_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [MAX_LEN-1:0] hist_next;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   fill_inc;
    logic [CNT_W-1:0]   cnt_inc;
    logic               hit;

    // Zero length means a single-bit pattern; oversize lengths use the full window.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        if (l == '0) begin
            return LEN_W'(1);
        end else if (int'(l) > MAX_LEN) begin
            return LEN_W'(MAX_LEN);
        end else begin
            return l;
        end
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
        hist_next = {hist_q[MAX_LEN-2:0], bit_in};
        fill_inc  = (int'(fill_q) >= MAX_LEN) ? LEN_W'(MAX_LEN) : fill_q + 1'b1;
        cnt_inc   = sat_inc(cnt_q);
        hit       = (fill_inc >= len_q) && (((hist_next ^ pat_q) & len_mask) == '0);
    end

    always_comb begin
        state_d      = state_q;
        pat_d        = pat_q;
        len_d        = len_q;
        overlap_d    = overlap_q;
        target_d     = target_q;
        cfg_loaded_d = cfg_loaded_q;
        hist_d       = hist_q;
        fill_d       = fill_q;
        match_d      = 1'b0;
        cnt_d        = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    pat_d        = cfg_pattern;
                    len_d        = clamp_len(cfg_len);
                    overlap_d    = cfg_overlap;
                    target_d     = cfg_target;
                    cfg_loaded_d = 1'b1;
                end
                if (start && (cfg_loaded_q || cfg_valid)) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    hist_d  = '0;
                    fill_d  = '0;
                end
            end
            S_RUN: begin
                // Abort wins over a same-cycle bit: the bit is dropped entirely.
                if (abort) begin
                    state_d = S_IDLE;
                end else if (bit_valid) begin
                    hist_d = hist_next;
                    fill_d = fill_inc;
                    if (hit) begin
                        match_d = 1'b1;
                        cnt_d   = cnt_inc;
                        if (!overlap_q) begin
                            fill_d = '0;
                        end
                        if ((target_q != '0) && (cnt_inc == target_q)) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pat_q        <= '0;
            len_q        <= '0;
            overlap_q    <= 1'b0;
            target_q     <= '0;
            cfg_loaded_q <= 1'b0;
            hist_q       <= '0;
            fill_q       <= '0;
            match_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pat_q        <= pat_d;
            len_q        <= len_d;
            overlap_q    <= overlap_d;
            target_q     <= target_d;
            cfg_loaded_q <= cfg_loaded_d;
            hist_q       <= hist_d;
            fill_q       <= fill_d;
            match_q      <= match_d;
            cnt_q        <= cnt_d;
        end
    end

    assign cfg_ready   = (state_q == S_IDLE);
    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign match       = match_q;
    assign match_count = cnt_q;
    assign state       = state_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Scoreboard bench for seq_det_ctrl: a queue-based reference model predicts
// every post-edge output; a negedge monitor pops and compares.
module tb_seq_det_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic [7:0] cfg_target = '0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;
    logic       match;
    logic [7:0] match_count;
    logic       busy;
    logic       done;
    logic [1:0] state;

    seq_det_ctrl #(.MAX_LEN(8), .CNT_W(8), .LEN_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cfg_target(cfg_target), .start(start), .abort(abort),
        .bit_valid(bit_valid), .bit_in(bit_in), .match(match),
        .match_count(match_count), .busy(busy), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       match;
        logic [7:0] cnt;
        logic       busy;
        logic       done;
        logic       rdy;
        logic [1:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: 0 idle, 1 run, 2 done; window holds bits since last fill reset.
    int       m_state;
    bit [7:0] m_pat;
    int       m_len;
    bit       m_ovl;
    int       m_tgt;
    bit       m_loaded;
    bit       win[$];
    int       m_cnt;
    bit       m_match;

    function automatic int eff_len(int l);
        if (l == 0) return 1;
        if (l > 8) return 8;
        return l;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_pat = '0; m_len = 0; m_ovl = 0; m_tgt = 0;
        m_loaded = 0; win.delete(); m_cnt = 0; m_match = 0;
    endtask

    task automatic model_step();
        bit   hit;
        exp_t e;
        if (!rst_n) begin
            model_reset();
        end else begin
            case (m_state)
                0: begin
                    m_match = 0;
                    if (cfg_valid) begin
                        m_pat = cfg_pattern; m_len = eff_len(int'(cfg_len));
                        m_ovl = cfg_overlap; m_tgt = int'(cfg_target); m_loaded = 1;
                    end
                    if (start && m_loaded) begin
                        m_state = 1; m_cnt = 0; win.delete();
                    end
                end
                1: begin
                    m_match = 0;
                    if (abort) begin
                        m_state = 0;
                    end else if (bit_valid) begin
                        win.push_back(bit_in);
                        if (win.size() > 8) void'(win.pop_front());
                        hit = 0;
                        if (win.size() >= m_len) begin
                            hit = 1;
                            for (int i = 0; i < m_len; i++)
                                if (win[win.size() - m_len + i] != m_pat[m_len - 1 - i]) hit = 0;
                        end
                        if (hit) begin
                            m_match = 1;
                            if (m_cnt < 255) m_cnt++;
                            if (!m_ovl) win.delete();
                            if (m_tgt != 0 && m_cnt == m_tgt) m_state = 2;
                        end
                    end
                end
                default: begin
                    m_match = 0;
                    m_state = 0;
                end
            endcase
        end
        e.match = m_match; e.cnt = 8'(m_cnt); e.busy = (m_state == 1);
        e.done = (m_state == 2); e.rdy = (m_state == 0); e.st = 2'(m_state);
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("match", 32'(match), 32'(e.match));
            chk("match_count", 32'(match_count), 32'(e.cnt));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("done", 32'(done), 32'(e.done));
            chk("cfg_ready", 32'(cfg_ready), 32'(e.rdy));
            chk("state", 32'(state), 32'(e.st));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic [7:0] t);
        cfg_valid = 1; cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_target = t;
        tick();
        cfg_valid = 0;
    endtask

    task automatic go();
        start = 1; tick(); start = 0;
    endtask

    task automatic send(input logic b, input logic ab);
        bit_valid = 1; bit_in = b; abort = ab;
        tick();
        bit_valid = 0; abort = 0;
    endtask

    task automatic stop_run();
        abort = 1; tick(); abort = 0; tick();
    endtask

    initial begin
        logic [6:0] s7;
        model_reset();
        repeat (3) tick();
        rst_n = 1;
        tick();

        // overlapping 0110 on 0110110
        cfg(8'b0000_0110, 4'd4, 1'b1, 8'd0);
        go();
        s7 = 7'b0110110;
        for (int i = 6; i >= 0; i--) send(s7[i], 1'b0);
        repeat (2) tick();
        stop_run();

        // non-overlapping on the same stream
        cfg(8'b0000_0110, 4'd4, 1'b0, 8'd0);
        go();
        for (int i = 6; i >= 0; i--) send(s7[i], 1'b0);
        stop_run();

        // target termination on 11 with five ones
        cfg(8'b0000_0011, 4'd2, 1'b1, 8'd3);
        go();
        repeat (5) send(1'b1, 1'b0);
        repeat (2) tick();

        // abort colliding with the completing bit
        cfg(8'b0000_0110, 4'd4, 1'b1, 8'd0);
        go();
        send(1'b0, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0);
        send(1'b0, 1'b1);
        repeat (2) tick();

        // config offered during RUN is ignored, then zero length clamps to one
        start = 1; cfg_valid = 1; tick(); start = 0; cfg_valid = 0;
        cfg(8'hFF, 4'd0, 1'b0, 8'd1);
        send(1'b0, 1'b0); send(1'b1, 1'b1);
        tick();
        cfg(8'h01, 4'd0, 1'b1, 8'd0);
        go();
        send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0);
        stop_run();
        cfg(8'h00, 4'd12, 1'b1, 8'd0);
        go();
        repeat (10) send(1'b0, 1'b0);
        stop_run();

        // asynchronous reset while match is high
        cfg(8'b0000_0110, 4'd4, 1'b1, 8'd0);
        go();
        send(1'b0, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("rst_match", 32'(match), 32'd0);
        chk("rst_count", 32'(match_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        chk("rst_state", 32'(state), 32'd0);
        model_reset();
        repeat (2) tick();
        rst_n = 1;
        tick();
        go();
        send(1'b0, 1'b0);
        tick();

        // randomized runs
        for (int r = 0; r < 60; r++) begin
            cfg_valid   = (r == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            cfg_pattern = 8'($urandom);
            cfg_len     = 4'($urandom_range(0, 15));
            cfg_overlap = 1'($urandom);
            cfg_target  = 8'($urandom_range(0, 4));
            start       = 1'($urandom_range(0, 3) != 0);
            tick();
            cfg_valid = 0; start = 0;
            for (int c = 0; c < 40; c++) begin
                bit_valid   = 1'($urandom_range(0, 9) < 7);
                bit_in      = 1'($urandom);
                abort       = 1'($urandom_range(0, 39) == 0);
                cfg_valid   = 1'($urandom_range(0, 19) == 0);
                cfg_pattern = 8'($urandom);
                cfg_len     = 4'($urandom_range(0, 15));
                start       = 1'($urandom_range(0, 19) == 0);
                tick();
            end
            bit_valid = 0; abort = 0; cfg_valid = 0; start = 0;
            stop_run();
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
